// File: rtl/perceptron_weight_update_pkg.sv
// Shared widths, FSM encoding, error codes and weight limits for the
// perceptron training datapath.
package perceptron_defs;

  localparam int DATA_W = 18;
  localparam int SUM_W  = 48;
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    UPDATE  = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Two's-complement encoding of the per-sample error: +1, 0, -1.
  localparam logic [1:0] ERR_POS  = 2'b01;
  localparam logic [1:0] ERR_ZERO = 2'b00;
  localparam logic [1:0] ERR_NEG  = 2'b11;

  localparam logic signed [DATA_W-1:0] W_MAX = 18'sh1FFFF;
  localparam logic signed [DATA_W-1:0] W_MIN = 18'sh20000;

endpackage

// File: rtl/perceptron_weight_update_if.sv
// Sample/result bundle between a training-sample source and the weight
// update block; also carries the FSM state for observation.
interface perceptron_weight_update_if #(
  parameter int N = 8
);
  import perceptron_defs::*;

  // Handshake: a sample transfers on a rising edge where in_valid and
  // in_ready are both 1. x/sum/target only need to be stable in that cycle;
  // in_valid is ignored while in_ready is 0. done pulses for one cycle when
  // the sample is finished, and only then is w meaningful downstream.
  logic [DATA_W*N-1:0]     x;
  logic signed [SUM_W-1:0] sum;
  logic                    target;
  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_W*N-1:0]     w;
  logic                    done;
  logic [1:0]              err;
  logic [CNT_W-1:0]        mistakes;
  state_t                  state;

  modport master (
    output x, sum, target, in_valid,
    input  in_ready, w, done, err, mistakes, state
  );

  modport slave (
    input  x, sum, target, in_valid,
    output in_ready, w, done, err, mistakes, state
  );

endinterface

// File: rtl/perceptron_weight_alu.sv
// Combinational single-weight update: w +/- (x >>> LR_SHIFT), with wrap or
// clamp selected by PERCEPTRON_WEIGHT_SAT_EN (clamp when defined).
module perceptron_weight_alu
  import perceptron_defs::*;
#(
  parameter int LR_SHIFT = 0
) (
  input  logic signed [DATA_W-1:0] w_cur,
  input  logic signed [DATA_W-1:0] x_cur,
  input  logic [1:0]               err,
  output logic signed [DATA_W-1:0] w_new
);

  logic signed [DATA_W-1:0] delta;
  logic signed [DATA_W:0]   w_ext;
  logic signed [DATA_W:0]   d_ext;
  logic signed [DATA_W:0]   acc;

  assign delta = x_cur >>> LR_SHIFT;
  assign w_ext = {w_cur[DATA_W-1], w_cur};
  assign d_ext = {delta[DATA_W-1], delta};

  always_comb begin
    acc = w_ext;
    case (err)
      ERR_POS: acc = w_ext + d_ext;
      ERR_NEG: acc = w_ext - d_ext;
      default: acc = w_ext;
    endcase
  end

`ifdef PERCEPTRON_WEIGHT_SAT_EN
  always_comb begin
    w_new = acc[DATA_W-1:0];
    if (acc > W_MAX) begin
      w_new = W_MAX;
    end else if (acc < W_MIN) begin
      w_new = W_MIN;
    end
  end
`else
  assign w_new = acc[DATA_W-1:0];
`endif

endmodule

// File: rtl/perceptron_weight_update.sv
// Perceptron learning-rule engine: classifies one captured sample and, on a
// mistake, walks the weights one per cycle. Optional PERCEPTRON_WEIGHT_SAT_EN.
module perceptron_weight_update
  import perceptron_defs::*;
#(
  parameter int                      N        = 8,
  parameter int                      LR_SHIFT = 0,
  parameter logic signed [SUM_W-1:0] THRESH   = 48'sd0
) (
  input logic                      clk,
  input logic                      rst,
  perceptron_weight_update_if.slave bus
);

  localparam int                 IDX_W    = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(N - 1);

  state_t                  state;
  state_t                  state_n;
  logic [IDX_W-1:0]        idx;
  logic [IDX_W-1:0]        idx_n;
  logic signed [DATA_W-1:0] x_q [N];
  logic signed [DATA_W-1:0] w_q [N];
  logic signed [SUM_W-1:0] sum_q;
  logic                    target_q;
  logic [1:0]              err_q;
  logic [1:0]              err_calc;
  logic [CNT_W-1:0]        mistakes_q;
  logic                    y;
  logic                    capture;
  logic                    load_err;
  logic                    do_update;
  logic signed [DATA_W-1:0] w_next;

  assign y = (sum_q >= THRESH);

  // err = target - y, restricted to the three legal codes.
  always_comb begin
    err_calc = ERR_ZERO;
    if (target_q && !y) begin
      err_calc = ERR_POS;
    end else if (!target_q && y) begin
      err_calc = ERR_NEG;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    capture   = 1'b0;
    load_err  = 1'b0;
    do_update = 1'b0;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          capture = 1'b1;
          state_n = COMPARE;
        end
      end
      COMPARE: begin
        load_err = 1'b1;
        idx_n    = '0;
        if (err_calc == ERR_ZERO) begin
          state_n = DONE;
        end else begin
          state_n = UPDATE;
        end
      end
      UPDATE: begin
        do_update = 1'b1;
        if (idx == IDX_LAST) begin
          state_n = DONE;
        end else begin
          idx_n = idx + IDX_W'(1);
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Sample registers need no reset: they are only read after a fresh capture.
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int i = 0; i < N; i++) begin
        x_q[i] <= bus.x[DATA_W*i +: DATA_W];
      end
      sum_q    <= bus.sum;
      target_q <= bus.target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        w_q[i] <= '0;
      end
      idx        <= '0;
      err_q      <= ERR_ZERO;
      mistakes_q <= '0;
    end else begin
      idx <= idx_n;
      if (load_err) begin
        err_q <= err_calc;
        if ((err_calc != ERR_ZERO) && (mistakes_q != '1)) begin
          mistakes_q <= mistakes_q + CNT_W'(1);
        end
      end
      if (do_update) begin
        w_q[idx] <= w_next;
      end
    end
  end

  perceptron_weight_alu #(
    .LR_SHIFT (LR_SHIFT)
  ) u_alu (
    .w_cur (w_q[idx]),
    .x_cur (x_q[idx]),
    .err   (err_q),
    .w_new (w_next)
  );

  for (genvar g = 0; g < N; g++) begin : g_wbus
    assign bus.w[DATA_W*g +: DATA_W] = w_q[g];
  end

  assign bus.in_ready = (state == IDLE);
  assign bus.done     = (state == DONE);
  assign bus.err      = err_q;
  assign bus.mistakes = mistakes_q;
  assign bus.state    = state;

endmodule

// File: tb/tb_perceptron_weight_update.sv
// Bench for perceptron_weight_update: two instances (LR_SHIFT 0 and 1) share
// one sample stream and are compared against an arithmetic learning-rule model.
module tb_perceptron_weight_update;

  localparam int                 N      = 8;
  localparam logic signed [47:0] THRESH = 48'sd0;
  localparam int                 SH0    = 0;
  localparam int                 SH1    = 1;

  logic               clk;
  logic               rst;
  logic [18*N-1:0]    x_bus;
  logic signed [47:0] sum_bus;
  logic               target_bus;
  logic               in_valid;

  int          tests_run;
  int          failed;
  int          stim_x [N];
  int          m_w [2][N];
  int          m_mist;
  logic [1:0]  exp_q [$];

  logic [1:0]      err_o  [2];
  logic [15:0]     mist_o [2];
  logic [18*N-1:0] w_o    [2];
  logic            done_o [2];
  logic            rdy_o  [2];

  perceptron_weight_update_if #(.N(N)) if0 ();
  perceptron_weight_update_if #(.N(N)) if1 ();

  assign if0.x = x_bus;  assign if0.sum = sum_bus;
  assign if0.target = target_bus;  assign if0.in_valid = in_valid;
  assign if1.x = x_bus;  assign if1.sum = sum_bus;
  assign if1.target = target_bus;  assign if1.in_valid = in_valid;

  assign err_o[0] = if0.err;      assign err_o[1] = if1.err;
  assign mist_o[0] = if0.mistakes; assign mist_o[1] = if1.mistakes;
  assign w_o[0] = if0.w;          assign w_o[1] = if1.w;
  assign done_o[0] = if0.done;    assign done_o[1] = if1.done;
  assign rdy_o[0] = if0.in_ready; assign rdy_o[1] = if1.in_ready;

  perceptron_weight_update #(.N(N), .LR_SHIFT(SH0), .THRESH(THRESH)) dut0 (
    .clk (clk), .rst (rst), .bus (if0.slave)
  );
  perceptron_weight_update #(.N(N), .LR_SHIFT(SH1), .THRESH(THRESH)) dut1 (
    .clk (clk), .rst (rst), .bus (if1.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int apply_rule(int w, int x, int e, int sh);
    int r;
`ifdef PERCEPTRON_WEIGHT_SAT_EN
    r = w + e * (x >>> sh);
    if (r > 131071) r = 131071;
    else if (r < -131072) r = -131072;
    return r;
`else
    logic signed [17:0] t;
    r = w + e * (x >>> sh);
    t = r[17:0];
    return int'(t);
`endif
  endfunction

  function automatic logic [18*N-1:0] pack_w(int d);
    logic [18*N-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[18*i +: 18] = 18'(m_w[d][i]);
    return v;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < N; i++) m_w[d][i] = 0;
    m_mist = 0;
    exp_q.delete();
  endtask

  task automatic model_sample(input longint s, input bit t);
    int y;
    int e;
    y = (s >= longint'(THRESH)) ? 1 : 0;
    e = int'(t) - y;
    if (e != 0) begin
      for (int d = 0; d < 2; d++)
        for (int i = 0; i < N; i++)
          m_w[d][i] = apply_rule(m_w[d][i], stim_x[i], e, (d == 0) ? SH0 : SH1);
      if (m_mist < 65535) m_mist++;
    end
    exp_q.push_back(2'(e));
  endtask

  // ---------------- driver ----------------
  // Presents stim_x/s/t in an IDLE cycle and returns at the negedge of the
  // done cycle; lat is cycles from accept to done, 0 on timeout.
  task automatic drive_sample(input longint s, input bit t, input bit hold, output int lat);
    @(negedge clk);
    for (int i = 0; i < N; i++) x_bus[18*i +: 18] = 18'(stim_x[i]);
    sum_bus    = 48'(s);
    target_bus = t;
    in_valid   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    lat = 1;
    if (!hold) begin
      in_valid   = 1'b0;
      x_bus      = {N{18'($urandom)}};
      sum_bus    = 48'($urandom);
      target_bus = ~t;
    end
    while (if0.done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (if0.done !== 1'b1) lat = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    x_bus = '0; sum_bus = '0; target_bus = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      tests_run++;
      if (w_o[d] !== '0) begin
        failed++; $display("FAIL reset_w dut%0d: got %h expected 0", d, w_o[d]);
      end
      tests_run++;
      if ({rdy_o[d], done_o[d], err_o[d], mist_o[d]} !== {1'b1, 1'b0, 2'b00, 16'd0}) begin
        failed++;
        $display("FAIL reset_ctrl dut%0d: ready=%b done=%b err=%b mistakes=%0d required 1 0 00 0",
                 d, rdy_o[d], done_o[d], err_o[d], mist_o[d]);
      end
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_basic();
    longint sums [4] = '{0, -5, 100, 100};
    bit     tgts [4] = '{1, 1, 0, 0};
    int     lat;
    int     exp_lat;
    logic [1:0] exp_e;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < N; i++)
        case (k)
          0: stim_x[i] = int'($urandom_range(0, 262143)) - 131072;
          1: stim_x[i] = i + 1;
          2: stim_x[i] = 1;
          default: stim_x[i] = 4;
        endcase
      model_sample(sums[k], tgts[k]);
      drive_sample(sums[k], tgts[k], 1'b0, lat);
      exp_e   = exp_q.pop_front();
      exp_lat = (exp_e == 2'b00) ? 2 : N + 2;
      tests_run++;
      if (lat != exp_lat) begin
        failed++; $display("FAIL basic%0d latency: got %0d expected %0d", k, lat, exp_lat);
      end
      for (int d = 0; d < 2; d++) begin
        tests_run++;
        if (err_o[d] !== exp_e) begin
          failed++; $display("FAIL basic%0d err dut%0d: got %b expected %b", k, d, err_o[d], exp_e);
        end
        tests_run++;
        if (mist_o[d] !== 16'(m_mist)) begin
          failed++; $display("FAIL basic%0d mistakes dut%0d: got %0d expected %0d", k, d, mist_o[d], m_mist);
        end
        tests_run++;
        if (w_o[d] !== pack_w(d)) begin
          failed++; $display("FAIL basic%0d w dut%0d: got %h expected %h", k, d, w_o[d], pack_w(d));
        end
      end
    end
  endtask

  task automatic test_saturation();
    int lat;
    int exp_w0;
    logic [1:0] exp_e;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < N; i++) stim_x[i] = 0;
      stim_x[0] = (k == 0) ? 131070 : 5;
      model_sample(-1, 1'b1);
      drive_sample(-1, 1'b1, 1'b0, lat);
      exp_e = exp_q.pop_front();
      tests_run++;
      if (lat != N + 2) begin
        failed++; $display("FAIL sat%0d latency: got %0d expected %0d", k, lat, N + 2);
      end
      for (int d = 0; d < 2; d++) begin
        tests_run++;
        if (err_o[d] !== exp_e || mist_o[d] !== 16'(m_mist)) begin
          failed++;
          $display("FAIL sat%0d err/mistakes dut%0d: got %b/%0d expected %b/%0d",
                   k, d, err_o[d], mist_o[d], exp_e, m_mist);
        end
        tests_run++;
        if (w_o[d] !== pack_w(d)) begin
          failed++; $display("FAIL sat%0d w dut%0d: got %h expected %h", k, d, w_o[d], pack_w(d));
        end
      end
    end
`ifdef PERCEPTRON_WEIGHT_SAT_EN
    exp_w0 = 131071;
`else
    exp_w0 = -131069;
`endif
    tests_run++;
    if (int'($signed(if0.w[17:0])) != exp_w0) begin
      failed++; $display("FAIL sat_w0 boundary: got %0d expected %0d", $signed(if0.w[17:0]), exp_w0);
    end
  endtask

  task automatic test_random();
    int lat;
    int exp_lat;
    longint s;
    bit t;
    logic [1:0] exp_e;
    for (int k = 0; k < 20; k++) begin
      for (int i = 0; i < N; i++) stim_x[i] = int'($urandom_range(0, 262143)) - 131072;
      s = (k % 5 == 4) ? longint'($urandom) * 4096 - 64'sd1 * longint'($urandom) * 4096
                       : longint'($urandom_range(0, 40)) - 20;
      t = 1'($urandom_range(0, 1));
      model_sample(s, t);
      drive_sample(s, t, 1'b0, lat);
      exp_e   = exp_q.pop_front();
      exp_lat = (exp_e == 2'b00) ? 2 : N + 2;
      tests_run++;
      if (lat != exp_lat) begin
        failed++; $display("FAIL rand%0d latency: got %0d expected %0d", k, lat, exp_lat);
      end
      for (int d = 0; d < 2; d++) begin
        tests_run++;
        if (err_o[d] !== exp_e || mist_o[d] !== 16'(m_mist)) begin
          failed++;
          $display("FAIL rand%0d err/mistakes dut%0d: got %b/%0d expected %b/%0d",
                   k, d, err_o[d], mist_o[d], exp_e, m_mist);
        end
        tests_run++;
        if (w_o[d] !== pack_w(d)) begin
          failed++; $display("FAIL rand%0d w dut%0d: got %h expected %h", k, d, w_o[d], pack_w(d));
        end
      end
    end
  endtask

  // in_valid stays high through busy cycles; each sample must be captured once.
  task automatic test_back_to_back();
    int lat;
    logic [1:0] exp_e;
    for (int i = 0; i < N; i++) stim_x[i] = int'($urandom_range(0, 2000)) - 1000;
    for (int k = 0; k < 3; k++) begin
      model_sample(-7, 1'b1);
      drive_sample(-7, 1'b1, 1'b1, lat);
      exp_e = exp_q.pop_front();
      tests_run++;
      if (lat != N + 2) begin
        failed++; $display("FAIL b2b%0d latency: got %0d expected %0d", k, lat, N + 2);
      end
      for (int d = 0; d < 2; d++) begin
        tests_run++;
        if (err_o[d] !== exp_e || mist_o[d] !== 16'(m_mist) || w_o[d] !== pack_w(d)) begin
          failed++;
          $display("FAIL b2b%0d dut%0d: err=%b mistakes=%0d w=%h expected %b %0d %h",
                   k, d, err_o[d], mist_o[d], w_o[d], exp_e, m_mist, pack_w(d));
        end
      end
    end
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    tests_run++;
    if (mist_o[0] !== 16'(m_mist) || if0.in_ready !== 1'b1) begin
      failed++;
      $display("FAIL b2b_idle: mistakes=%0d ready=%b expected %0d 1", mist_o[0], if0.in_ready, m_mist);
    end
  endtask

  task automatic test_reset_mid_update();
    int  k;
    bit  saw_done;
    for (int i = 0; i < N; i++) stim_x[i] = int'($urandom_range(1, 5000));
    @(negedge clk);
    for (int i = 0; i < N; i++) x_bus[18*i +: 18] = 18'(stim_x[i]);
    sum_bus = -48'sd5; target_bus = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    k = 0;
    repeat (5) begin @(negedge clk); k++; end
    tests_run++;
    if (int'($signed(if0.w[17:0])) != apply_rule(m_w[0][0], stim_x[0], 1, SH0)) begin
      failed++;
      $display("FAIL rst_mid pre w0: got %0d expected %0d", $signed(if0.w[17:0]),
               apply_rule(m_w[0][0], stim_x[0], 1, SH0));
    end
    rst = 1'b1;
    @(negedge clk);
    model_reset();
    for (int d = 0; d < 2; d++) begin
      tests_run++;
      if (w_o[d] !== '0 || rdy_o[d] !== 1'b1 || done_o[d] !== 1'b0 || mist_o[d] !== 16'd0) begin
        failed++;
        $display("FAIL rst_mid dut%0d: w=%h ready=%b done=%b mistakes=%0d expected 0 1 0 0",
                 d, w_o[d], rdy_o[d], done_o[d], mist_o[d]);
      end
    end
    rst = 1'b0;
    in_valid = 1'b0;
    saw_done = 1'b0;
    repeat (N + 4) begin
      @(negedge clk);
      if (if0.done === 1'b1 || if1.done === 1'b1) saw_done = 1'b1;
    end
    tests_run++;
    if (saw_done || w_o[0] !== '0) begin
      failed++; $display("FAIL rst_mid after: done_seen=%b w=%h expected 0 0", saw_done, w_o[0]);
    end
  endtask

  initial begin
    tests_run = 0;
    failed    = 0;
    model_reset();
    test_reset();
    test_basic();
    test_back_to_back();
    test_reset_mid_update();
    test_saturation();
    test_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule

// File: doc/perceptron_weight_update.md
Name: perceptron_weight_update

Overview:
- Training-direction counterpart of the perceptron's weighted-sum datapath.
- Consumes one training sample: the inputs x, the target label, and the 48-bit weighted sum already produced for that x.
- Applies the perceptron learning rule w_i += err * (x_i >>> LR_SHIFT), one weight per cycle.
- Drives the flat weight bus w that feeds the weighted-sum cascade.

Parameters:
- N, 8: number of 18-bit signed inputs/weights.
- LR_SHIFT, 0: learning rate as a right arithmetic shift of x_i (0..17).
- THRESH, 48'sd0: signed activation threshold; y = 1 when sum >= THRESH.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- x  in  18*N  signed inputs, element i at bits [18*i+17:18*i].
- sum  in  48  signed weighted sum for this x.
- target  in  1  desired output label (0/1).
- in_valid  in  1  sample present on x/sum/target.
- in_ready  out  1  block can accept a sample.
- w  out  18*N  signed weight bus, same packing as x.
- done  out  1  one-cycle pulse when the sample is fully processed.
- err  out  2  signed error of the last sample: 2'b01 = +1, 2'b00 = 0, 2'b11 = -1.
- mistakes  out  16  count of samples with err != 0.

Behaviour:
- Reset: every w_i = 0, in_ready = 1, done = 0, err = 0, mistakes = 0, state IDLE.
- Reset has priority over all other activity, including mid-UPDATE. Captured sample is discarded and any partial weight updates are lost (all weights return to 0).
- FSM states: IDLE, COMPARE, UPDATE, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready (cycle T), register x, sum, target and move to COMPARE.
- COMPARE (T+1):
  - y = ($signed(sum) >= THRESH); err = target - y; err output is registered here.
  - err = 0 -> DONE.
  - err != 0 -> UPDATE with idx = 0; mistakes += 1, saturating at 65535.
- UPDATE (T+2 .. T+N+1):
  - Each cycle computes d = (x_idx >>> LR_SHIFT) in 18-bit signed, then w_idx <= w_idx + d (err = +1) or w_idx - d (err = -1).
  - The addition is 19-bit intermediate, then reduced to 18 bits (see Optional Feature).
  - idx increments each cycle; after idx = N-1 move to DONE.
- DONE:
  - err = 0 path: DONE at T+2.
  - err != 0 path: DONE at T+N+2.
  - done = 1 for exactly one cycle, then IDLE.
- in_ready = 0 in COMPARE, UPDATE and DONE; in_valid is ignored there and no sample is captured.
- w is registered. Element idx changes in the cycle after its UPDATE step; all other elements are stable. Downstream must sample w only after done.
- x/sum/target need only be valid during the accept cycle.
- err holds its value until the next COMPARE.

Optional Feature:
- Macro: PERCEPTRON_WEIGHT_SAT_EN.
- Defined: the 19-bit result is clamped to [-131072, 131071].
- Undefined: the result is truncated to its low 18 bits (two's-complement wrap).

Decomposition:
- Shared package/header perceptron_defs holds:
  - widths: DATA_W = 18, SUM_W = 48, CNT_W = 16;
  - FSM state encodings;
  - err encodings ERR_POS, ERR_ZERO, ERR_NEG;
  - saturation limits W_MAX, W_MIN.
- One natural sub-module: perceptron_weight_alu (combinational). It takes w_idx, x_idx and err and produces the shifted, signed, optionally saturated new weight.

Test Plan:
- Reset -> w = 0 for all i, in_ready = 1, done = 0, mistakes = 0.
- Accept sum = 0, target = 1 (y = 1, err = 0) -> done at T+2, err = 2'b00, w unchanged, mistakes = 0.
- Accept sum = -5, target = 1, x_i = i+1 -> err = 2'b01; done at T+10 (N = 8); w_i = i+1; mistakes = 1.
- Then accept sum = 100, target = 0, x_i = 1, LR_SHIFT = 0 -> err = 2'b11, w_i = i, mistakes = 2. Repeat with LR_SHIFT = 1 and x_i = 4 -> each w_i decreases by 2.
- Drive w_0 to 131070, then train with err = +1 and x_0 = 5 -> w_0 = 131071 with PERCEPTRON_WEIGHT_SAT_EN, w_0 = -131069 without it.
- Hold in_valid = 1 throughout an err != 0 sample -> exactly one capture per IDLE cycle. Assert rst at T+5 -> next cycle all w = 0, in_ready = 1, no done pulse.
